// File: rtl/demux_dist.sv
// demux_dist: one-to-four demultiplexer with a one-entry register per channel,
// sel- or round-robin routing, and saturating per-channel delivered-word counters.
module demux_dist #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           rr_mode,
  input  logic [1:0]     sel,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic [3:0]     out_valid,
  output logic [4*W-1:0] out_data,
  input  logic [3:0]     out_ready,
  input  logic           clr_cnt,
  output logic [31:0]    cnt,
  output logic [1:0]     rr_ptr
);

  // Channel holding registers (stage 1, one cycle after accept)
  logic [W-1:0] data_p1 [4];
  logic [3:0]   vld_p1;
  logic [7:0]   cnt_r [4];
  logic [1:0]   ptr_r;

  logic [1:0]   tgt;
  logic         accept;
  logic [3:0]   drain;

  // Counters stop at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Target selection, handshake and per-channel drain decode.
  always_comb begin
    tgt      = rr_mode ? ptr_r : sel;
    in_ready = en & ~rst & (~vld_p1[tgt] | out_ready[tgt]);
    accept   = in_valid & in_ready;
    drain    = vld_p1 & out_ready;
  end

  // Channel registers: load on accept to the target, otherwise clear on drain.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        vld_p1[i]  <= 1'b0;
        data_p1[i] <= '0;
      end else if (accept && (tgt == 2'(i))) begin
        vld_p1[i]  <= 1'b1;
        data_p1[i] <= in_data;
      end else if (drain[i]) begin
        vld_p1[i]  <= 1'b0;
      end
    end
  end

  // Round-robin pointer advances only on accepts made in round-robin mode.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_r <= 2'd0;
    else if (accept && rr_mode)
      ptr_r <= ptr_r + 2'd1;
  end

  // Delivered-word counters; clear beats a simultaneous drain.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || clr_cnt)
        cnt_r[i] <= 8'd0;
      else if (drain[i])
        cnt_r[i] <= sat_inc(cnt_r[i]);
    end
  end

  // Flatten channel state onto the output buses.
  always_comb begin
    out_data = '0;
    cnt      = '0;
    for (int i = 0; i < 4; i++) begin
      out_data[i*W +: W] = data_p1[i];
      cnt[i*8 +: 8]      = cnt_r[i];
    end
    out_valid = vld_p1;
    rr_ptr    = ptr_r;
  end

endmodule

// File: tb/tb_demux_dist.sv
// tb_demux_dist: directed scenarios plus randomized traffic, every cycle compared
// against a queue-free behavioural model of the four channel slots.
module tb_demux_dist;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, en, rr_mode, in_valid, clr_cnt;
  logic [1:0]     sel;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [3:0]     out_valid, out_ready;
  logic [4*W-1:0] out_data;
  logic [31:0]    cnt;
  logic [1:0]     rr_ptr;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit       mv   [4];
  int       md   [4];
  int       mcnt [4];
  int       mptr;

  demux_dist #(.W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .rr_mode(rr_mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .cnt(cnt), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int model_target();
    return rr_mode ? mptr : int'(sel);
  endfunction

  function automatic bit model_ready();
    int t;
    t = model_target();
    return en && !rst && (!mv[t] || out_ready[t]);
  endfunction

  task automatic check_outputs();
    logic [3:0]  ev;
    logic [31:0] ed, ec;
    for (int i = 0; i < 4; i++) begin
      ev[i]        = mv[i];
      ed[i*8 +: 8] = 8'(md[i]);
      ec[i*8 +: 8] = 8'(mcnt[i]);
    end
    chk("in_ready",  32'(in_ready),  32'(model_ready()));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data",  out_data,       ed);
    chk("cnt",       cnt,            ec);
    chk("rr_ptr",    32'(rr_ptr),    32'(mptr));
  endtask

  task automatic model_update();
    int t;
    bit acc;
    t   = model_target();
    acc = in_valid && model_ready();
    if (rst) begin
      for (int i = 0; i < 4; i++) begin mv[i] = 0; md[i] = 0; mcnt[i] = 0; end
      mptr = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit dr;
        dr = mv[i] && out_ready[i];
        if (clr_cnt) mcnt[i] = 0;
        else if (dr && mcnt[i] < 255) mcnt[i]++;
        if (dr) mv[i] = 0;
      end
      if (acc) begin
        mv[t] = 1;
        md[t] = int'(in_data);
        if (rr_mode) mptr = (mptr + 1) % 4;
      end
    end
  endtask

  // Called at a falling edge with inputs already set.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1; rr_mode = 0; sel = 0; in_valid = 0; in_data = 0;
    out_ready = 4'b0000; clr_cnt = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    step();                               // reset state checked here
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_cnt",   cnt,            32'h0);
    rst = 0;

    // sel-routed accept to channel 2
    sel = 2; in_data = 8'hA5; in_valid = 1;
    step();
    in_valid = 0;
    #1;
    chk("sel_valid", 32'(out_valid),     32'h4);
    chk("sel_data",  32'(out_data[23:16]), 32'hA5);
    chk("sel_ready_full", 32'(in_ready), 32'h0);
    step();

    // drain and refill in the same cycle on channel 1
    sel = 1; in_data = 8'h11; in_valid = 1;
    step();
    out_ready = 4'b0010; in_data = 8'h22;
    step();
    in_valid = 0; out_ready = 4'b0000;
    chk("refill_valid", 32'(out_valid[1]),    32'h1);
    chk("refill_data",  32'(out_data[15:8]),  32'h22);
    chk("refill_cnt",   32'(cnt[15:8]),       32'h1);
    step();
    out_ready = 4'b1111;
    step();

    // round-robin order, counters cleared first
    clr_cnt = 1;
    step();
    clr_cnt = 0; rr_mode = 1; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(k + 1);
      step();
      chk("rr_valid", 32'(out_valid), 32'(1 << k));
      chk("rr_data",  32'(out_data[k*8 +: 8]), 32'(k + 1));
    end
    in_valid = 0;
    chk("rr_ptr_wrap", 32'(rr_ptr), 32'h0);
    step();
    chk("rr_counts", cnt, 32'h01010101);

    // saturation of channel 3 counter, then clear with concurrent drain
    rr_mode = 0; sel = 3; out_ready = 4'b1000; in_valid = 1;
    for (int k = 0; k < 302; k++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 0;
    step();
    chk("sat_cnt3", 32'(cnt[31:24]), 32'd255);
    out_ready = 4'b0000; in_valid = 1; in_data = 8'h3C;
    step();
    in_valid = 0; out_ready = 4'b1000; clr_cnt = 1;
    step();
    clr_cnt = 0; out_ready = 4'b0000;
    chk("clr_cnt3",  32'(cnt[31:24]),   32'h0);
    chk("clr_drain", 32'(out_valid[3]), 32'h0);

    // enable gating with a pending drain on channel 0
    sel = 0; in_data = 8'h5A; in_valid = 1;
    step();
    en = 0; in_data = 8'hFF; out_ready = 4'b0001;
    #1;
    chk("en_ready", 32'(in_ready), 32'h0);
    step();
    chk("en_noload", 32'(out_valid), 32'h0);
    en = 1; in_valid = 0; out_ready = 4'b0000;

    // mid-operation reset with all channels full and rr_ptr at 2
    rr_mode = 1; out_ready = 4'b1111; in_valid = 1;
    step();
    step();
    in_valid = 0;
    step();
    rr_mode = 0; out_ready = 4'b0000; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); in_data = 8'(8'h80 + k);
      step();
    end
    in_valid = 0;
    chk("pre_rst_valid", 32'(out_valid), 32'hF);
    chk("pre_rst_ptr",   32'(rr_ptr),    32'h2);
    rst = 1; out_ready = 4'b1111; in_valid = 1; clr_cnt = 1;
    step();
    rst = 0; out_ready = 4'b0000; in_valid = 0; clr_cnt = 0;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ptr",   32'(rr_ptr),    32'h0);
    chk("rst_cnt",   cnt,            32'h0);
    rr_mode = 1; in_valid = 1; in_data = 8'h77;
    step();
    in_valid = 0;
    chk("post_rst_rr", 32'(out_valid), 32'h1);
    chk("post_rst_data", 32'(out_data[7:0]), 32'h77);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      rst       = ($urandom_range(63) == 0);
      en        = ($urandom_range(7) != 0);
      rr_mode   = ($urandom_range(2) == 0);
      sel       = 2'($urandom);
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      clr_cnt   = ($urandom_range(31) == 0);
      step();
    end
    rst = 0;
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_dist.md
DEMUX_DIST -- requirements
Module: demux_dist

Interface
REQ-001 Parameter: W, default 8, data width of the input and of each output channel.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port: en  input  1  enable; when 0, no new input is accepted.
REQ-005 Port: rr_mode  input  1  routing mode: 0 routes by sel, 1 routes by the internal round-robin pointer.
REQ-006 Port: sel  input  2  target channel when rr_mode=0 (0..3).
REQ-007 Port: in_valid  input  1  source offers in_data this cycle.
REQ-008 Port: in_data  input  W  input word.
REQ-009 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-010 Port: out_valid  output  4  bit i high means channel i holds a word.
REQ-011 Port: out_data  output  4*W  channel i word on bits [i*W+W-1 : i*W].
REQ-012 Port: out_ready  input  4  bit i high means channel i's sink takes the word this cycle.
REQ-013 Port: clr_cnt  input  1  synchronous clear of all transfer counters.
REQ-014 Port: cnt  output  32  channel i's 8-bit delivered-word count on bits [8i+7 : 8i].
REQ-015 Port: rr_ptr  output  2  current round-robin pointer.

Function
REQ-016 Target channel t SHALL be sel when rr_mode=0, and rr_ptr when rr_mode=1.
REQ-017 Each channel SHALL hold a one-entry register (data plus a valid flag); out_valid[i] and out_data slice i SHALL be driven directly from that register.
REQ-018 in_ready SHALL equal en & (~out_valid[t] | out_ready[t]), combinationally.
REQ-019 Accept SHALL occur when in_valid & in_ready: channel t loads in_data and sets its valid flag, and no other channel changes due to the accept.
REQ-020 Latency SHALL be one cycle: a word accepted in cycle n SHALL be visible on channel t in cycle n+1.
REQ-021 Drain of channel i SHALL occur when out_valid[i] & out_ready[i]; the valid flag then clears, unless the same cycle also accepts into channel i, in which case it stays 1 and the data is replaced.
REQ-022 out_data slice i SHALL hold its value while out_valid[i]=1 and no drain occurs, regardless of in_data, sel or en.
REQ-023 With en=0, in_ready SHALL be 0, and channels SHALL still drain normally.
REQ-024 rr_ptr SHALL increment by 1 modulo 4 (3 -> 0) on each accept while rr_mode=1, and SHALL hold otherwise.
REQ-025 rr_ptr SHALL be retained across rr_mode changes.
REQ-026 cnt slice i SHALL increment by 1 on each drain of channel i and saturate at 255.
REQ-027 clr_cnt=1 SHALL set all counts to 0 and take priority over a simultaneous drain.
REQ-028 Multiple channels SHALL drain in the same cycle independently.
REQ-029 A sel change while a word waits SHALL NOT move or corrupt held words.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL set out_valid=0, out_data=0, rr_ptr=0 and cnt=0.
REQ-031 in_ready SHALL be 0 during any cycle where rst=1.
REQ-032 rst SHALL take priority over accept, drain and clr_cnt; a mid-transfer word SHALL be discarded without counting.
REQ-033 Normal operation SHALL resume on the first edge with rst=0.

Verification
REQ-034 The bench SHALL cover sel-routed accept: rr_mode=0, sel=2, in_data=0xA5, out_ready=0000 -> next cycle out_valid=0100, slice 2=0xA5, and in_ready=0 for sel=2.
REQ-035 The bench SHALL cover simultaneous drain and refill: channel 1 holds 0x11, out_ready[1]=1, accept 0x22 with sel=1 -> next cycle out_valid[1]=1, slice 1=0x22, cnt slice 1 +1.
REQ-036 The bench SHALL cover round-robin order: rr_mode=1, out_ready=1111, four accepts 0x01..0x04 -> each channel 0..3 receives one word in order, rr_ptr returns to 0, each count=1.
REQ-037 The bench SHALL cover counter saturation and clear: 300 drains on channel 3 -> cnt slice 3=255; then clr_cnt=1 with a drain in the same cycle -> slice 3=0.
REQ-038 The bench SHALL cover enable gating: en=0, in_valid=1 -> in_ready=0, no channel loads, and an existing word on channel 0 still drains with out_ready[0]=1.
REQ-039 The bench SHALL cover mid-operation reset: all channels valid, rr_ptr=2, rst=1 for one cycle -> out_valid=0000, rr_ptr=0, cnt=0, and the next accept goes to channel 0 in rr_mode.
